axi_lite_led_pwm_ctrl: RTL and testbench

AXI4-Lite slave register bank plus NUM_CH independent LED blink/PWM generators. It replaces the fixed three-channel RGB register block with a parametrised channel count, per-channel duty cycle and byte-strobe writes. It adds glitch-free period/duty updates and SLVERR on unmapped addresses. It sits between the PS AXI GP port and the board LED/buzzer pins.

---
 rtl/axi_lite_led_pwm_ctrl_if.sv | 36 +++
 rtl/axi_lite_led_pwm_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_axi_lite_led_pwm_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_led_pwm_ctrl_if.sv
// rtl/axi_lite_led_pwm_ctrl_if.sv - AXI4-Lite bus bundle for the LED/PWM register bank
interface axi_lite_led_pwm_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_led_pwm_ctrl.sv
// rtl/axi_lite_led_pwm_ctrl.sv - AXI4-Lite register bank driving NUM_CH LED blink/PWM channels
module axi_lite_led_pwm_ctrl #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 32
) (
    input  logic                    aclk,
    input  logic                    areset,
    axi_lite_led_pwm_ctrl_if.slave  s_axi,
    output logic [NUM_CH-1:0]       led_out
);
    localparam int         IDX_W    = ADDR_W - 2;
    localparam int         NUM_REGS = 1 + 3 * NUM_CH;
    localparam logic [1:0] RESP_OK  = 2'b00;
    localparam logic [1:0] RESP_ERR = 2'b10;

    logic              r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]        r_bresp, r_rresp;
    logic [31:0]       r_rdata;
    logic              r_run;
    logic [2:0]        r_ctrl   [NUM_CH];
    logic [CNT_W-1:0]  r_period [NUM_CH];
    logic [CNT_W-1:0]  r_duty   [NUM_CH];
    logic [CNT_W-1:0]  r_cnt    [NUM_CH];
    logic [CNT_W-1:0]  r_aper   [NUM_CH];
    logic [CNT_W-1:0]  r_aduty  [NUM_CH];
    logic [NUM_CH-1:0] r_led;

    logic [IDX_W-1:0]  w_widx, w_ridx;
    logic              w_wr_hs, w_rd_hs, w_wr_map, w_rd_map;
    logic [31:0]       w_rd_data;
    logic [NUM_CH-1:0] w_blink, w_wrap, w_blink_led;
    logic              w_unused;

    assign w_widx   = s_axi.awaddr[ADDR_W-1:2];
    assign w_ridx   = s_axi.araddr[ADDR_W-1:2];
    assign w_wr_map = int'(w_widx) < NUM_REGS;
    assign w_rd_map = int'(w_ridx) < NUM_REGS;
    // awready is only ever raised with wready, so it alone marks the write handshake edge
    assign w_wr_hs  = r_awready && s_axi.awvalid && s_axi.wvalid;
    assign w_rd_hs  = r_arready && s_axi.arvalid;
    assign w_unused = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0], r_wready};

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rresp   = r_rresp;
    assign s_axi.rdata   = r_rdata;
    assign led_out       = r_led;

    // Byte-lane merge of a write into a CNT_W-wide register
    function automatic logic [CNT_W-1:0] f_merge(input logic [CNT_W-1:0] old_v,
                                                 input logic [31:0] data,
                                                 input logic [3:0] strb);
        logic [31:0] v;
        v = '0;
        v[CNT_W-1:0] = old_v;
        for (int b = 0; b < 4; b++)
            if (strb[b]) v[8*b +: 8] = data[8*b +: 8];
        return v[CNT_W-1:0];
    endfunction

    // Write address/data handshake, register update and write response
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OK;
            r_run     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_ctrl[c]   <= '0;
                r_period[c] <= '0;
                r_duty[c]   <= '0;
            end
        end else begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            if (s_axi.awvalid && s_axi.wvalid && !r_awready && !r_bvalid) begin
                r_awready <= 1'b1;
                r_wready  <= 1'b1;
            end
            if (r_bvalid && s_axi.bready)
                r_bvalid <= 1'b0;
            if (w_wr_hs) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_map ? RESP_OK : RESP_ERR;
                if (w_widx == '0 && s_axi.wstrb[0])
                    r_run <= s_axi.wdata[0];
                for (int c = 0; c < NUM_CH; c++) begin
                    if (w_widx == IDX_W'(1 + 3*c) && s_axi.wstrb[0])
                        r_ctrl[c] <= s_axi.wdata[2:0];
                    if (w_widx == IDX_W'(2 + 3*c))
                        r_period[c] <= f_merge(r_period[c], s_axi.wdata, s_axi.wstrb);
                    if (w_widx == IDX_W'(3 + 3*c))
                        r_duty[c] <= f_merge(r_duty[c], s_axi.wdata, s_axi.wstrb);
                end
            end
        end
    end

    // Read mux; unmapped indices fall through to zero
    always_comb begin
        w_rd_data = '0;
        if (w_ridx == '0) begin
            w_rd_data[0]           = r_run;
            w_rd_data[8 +: NUM_CH] = r_led;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_ridx == IDX_W'(1 + 3*c)) w_rd_data[2:0]       = r_ctrl[c];
            if (w_ridx == IDX_W'(2 + 3*c)) w_rd_data[CNT_W-1:0] = r_period[c];
            if (w_ridx == IDX_W'(3 + 3*c)) w_rd_data[CNT_W-1:0] = r_duty[c];
        end
    end

    // Read address handshake and read data capture
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OK;
        end else begin
            r_arready <= 1'b0;
            if (s_axi.arvalid && !r_arready && !r_rvalid)
                r_arready <= 1'b1;
            if (r_rvalid && s_axi.rready)
                r_rvalid <= 1'b0;
            if (w_rd_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_map ? w_rd_data : 32'h0;
                r_rresp  <= w_rd_map ? RESP_OK : RESP_ERR;
            end
        end
    end

    // Per-channel blink decode from the active (shadowed) period and duty
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_blink[c] = r_run && r_ctrl[c][1] && r_ctrl[c][0];
            if (r_aper[c] <= CNT_W'(1)) begin
                w_wrap[c]      = 1'b1;
                w_blink_led[c] = (r_aduty[c] != '0);
            end else begin
                w_wrap[c]      = (r_cnt[c] >= r_aper[c] - CNT_W'(1));
                w_blink_led[c] = (r_aduty[c] >= r_aper[c]) || (r_cnt[c] < r_aduty[c]);
            end
        end
    end

    // Channel counters, shadow reload at wrap or while idle, and registered LED outputs
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_led <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_cnt[c]   <= '0;
                r_aper[c]  <= '0;
                r_aduty[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_blink[c]) begin
                    r_led[c] <= w_blink_led[c];
                    if (w_wrap[c]) begin
                        r_cnt[c]   <= '0;
                        r_aper[c]  <= r_period[c];
                        r_aduty[c] <= r_duty[c];
                    end else begin
                        r_cnt[c] <= r_cnt[c] + CNT_W'(1);
                    end
                end else begin
                    r_cnt[c]   <= '0;
                    r_aper[c]  <= r_period[c];
                    r_aduty[c] <= r_duty[c];
                    if (!r_run)
                        r_led[c] <= 1'b0;
                    else if (!r_ctrl[c][1])
                        r_led[c] <= r_ctrl[c][2] && r_led[c];
                    else
                        r_led[c] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_led_pwm_ctrl.sv
// tb/tb_axi_lite_led_pwm_ctrl.sv - directed self-checking bench for axi_lite_led_pwm_ctrl
module tb_axi_lite_led_pwm_ctrl;
    localparam int NUM_CH = 3;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 32;

    logic              aclk;
    logic              areset;
    logic [NUM_CH-1:0] led_out;
    int                checks;
    int                errors;

    axi_lite_led_pwm_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    axi_lite_led_pwm_ctrl #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .aclk    (aclk),
        .areset  (areset),
        .s_axi   (bus),
        .led_out (led_out)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        @(negedge aclk);
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(negedge aclk);
        n = 0;
        while (!bus.awready && n < 20) begin @(negedge aclk); n++; end
        chk("aw_latency", 32'(n), 32'd0);
        chk("wready_with_awready", 32'(bus.wready), 32'd1);
        @(negedge aclk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        n = 0;
        while (!bus.bvalid && n < 20) begin @(negedge aclk); n++; end
        chk("bvalid_latency", 32'(n), 32'd0);
        resp = bus.bresp;
        @(negedge aclk);
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output logic [NUM_CH-1:0] led_snap);
        int n;
        @(negedge aclk);
        bus.araddr = addr; bus.arvalid = 1'b1;
        @(negedge aclk);
        n = 0;
        while (!bus.arready && n < 20) begin @(negedge aclk); n++; end
        chk("ar_latency", 32'(n), 32'd0);
        led_snap = led_out;
        @(negedge aclk);
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        n = 0;
        while (!bus.rvalid && n < 20) begin @(negedge aclk); n++; end
        chk("rvalid_latency", 32'(n), 32'd0);
        data = bus.rdata; resp = bus.rresp;
        @(negedge aclk);
        bus.rready = 1'b0;
    endtask

    task automatic wait_rise0(output logic rise);
        logic prev;
        int   n;
        prev = led_out[0];
        n = 0;
        rise = 1'b0;
        do begin
            @(negedge aclk);
            rise = !prev && led_out[0];
            prev = led_out[0];
            n++;
        end while (!rise && n < 60);
        chk("led0_rise_seen", 32'(rise), 32'd1);
    endtask

    initial begin
        logic [1:0]        resp;
        logic [31:0]       data;
        logic [NUM_CH-1:0] snap;
        logic              rise;
        logic [19:0]       pat20;
        logic [23:0]       pat24;
        int                n;
        checks = 0; errors = 0;
        areset = 1'b1;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);

        // reset state
        chk("rst_led", 32'(led_out), 32'd0);
        chk("rst_handshakes", 32'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}), 32'd0);
        chk("rst_resp", 32'({bus.bresp, bus.rresp}), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        axi_read(8'h00, data, resp, snap);
        chk("rst_global", data, 32'h0);
        chk("rst_global_rresp", 32'(resp), 32'd0);

        // channel 0 blink: 3 high / 7 low
        axi_write(8'h00, 32'h1, 4'hF, resp);
        chk("wr_global_bresp", 32'(resp), 32'd0);
        axi_write(8'h08, 32'd10, 4'hF, resp);
        axi_write(8'h0C, 32'd3, 4'hF, resp);
        axi_write(8'h04, 32'h3, 4'hF, resp);
        wait_rise0(rise);
        pat20[19] = led_out[0];
        for (int i = 1; i < 20; i++) begin @(negedge aclk); pat20[19-i] = led_out[0]; end
        chk("blink_10_3", 32'(pat20), 32'(20'b11100000001110000000));
        axi_read(8'h00, data, resp, snap);
        chk("global_tracks_led", data, 32'h1 | (32'(snap) << 8));

        // period change mid-cycle takes effect only at the wrap
        wait_rise0(rise);
        fork
            begin
                pat24[23] = led_out[0];
                for (int i = 1; i < 24; i++) begin @(negedge aclk); pat24[23-i] = led_out[0]; end
            end
            begin
                repeat (2) @(negedge aclk);
                axi_write(8'h08, 32'd4, 4'hF, resp);
            end
        join
        chk("shadowed_period", 32'(pat24), 32'(24'b111000000011101110111011));

        // byte strobes
        axi_write(8'h14, 32'hAABBCCDD, 4'b0101, resp);
        axi_read(8'h14, data, resp, snap);
        chk("wstrb_merge", data, 32'h00BB00DD);

        // last mapped register, then first unmapped index
        axi_write(8'h24, 32'h12345678, 4'hF, resp);
        chk("last_mapped_bresp", 32'(resp), 32'd0);
        axi_read(8'h24, data, resp, snap);
        chk("last_mapped_rdata", data, 32'h12345678);
        axi_write(8'h28, 32'hFFFFFFFF, 4'hF, resp);
        chk("unmapped_bresp", 32'(resp), 32'd2);
        axi_read(8'h28, data, resp, snap);
        chk("unmapped_rresp", 32'(resp), 32'd2);
        chk("unmapped_rdata", data, 32'h0);
        axi_read(8'h08, data, resp, snap);
        chk("period0_untouched", data, 32'd4);
        axi_read(8'h0C, data, resp, snap);
        chk("duty0_untouched", data, 32'd3);

        // constant mode, hold, release, RUN gating
        axi_write(8'h04, 32'h2, 4'hF, resp);
        repeat (2) @(negedge aclk);
        chk("const_on", 32'(led_out), 32'b001);
        axi_write(8'h04, 32'h5, 4'hF, resp);
        repeat (5) @(negedge aclk);
        chk("hold_keeps_1", 32'(led_out), 32'b001);
        axi_write(8'h04, 32'h1, 4'hF, resp);
        repeat (2) @(negedge aclk);
        chk("disable_no_hold", 32'(led_out), 32'b000);
        axi_write(8'h04, 32'h2, 4'hF, resp);
        axi_write(8'h00, 32'h0, 4'hF, resp);
        chk("run_off", 32'(led_out), 32'b000);

        // reset in the middle of a write
        @(negedge aclk);
        bus.awaddr = 8'h20; bus.wdata = 32'hDEAD; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        n = 0;
        do begin @(negedge aclk); n++; end while (!bus.awready && n < 20);
        chk("abort_awready_seen", 32'(bus.awready), 32'd1);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("abort_handshakes_low", 32'({bus.awready, bus.wready, bus.bvalid}), 32'd0);
        n = 0;
        for (int i = 0; i < 6; i++) begin @(negedge aclk); if (bus.bvalid) n++; end
        chk("abort_no_bvalid", 32'(n), 32'd0);
        chk("abort_led", 32'(led_out), 32'd0);
        axi_read(8'h20, data, resp, snap);
        chk("abort_period2", data, 32'h0);
        axi_read(8'h24, data, resp, snap);
        chk("abort_duty2", data, 32'h0);
        axi_read(8'h14, data, resp, snap);
        chk("abort_period1", data, 32'h0);
        axi_read(8'h04, data, resp, snap);
        chk("abort_ctrl0", data, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
